// File: rtl/ascii_pkg.sv
// Shared constants and FSM encoding for the ASCII hex transmit path.
// Character codes match what the receive-side display decoder understands.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase hex ASCII encoder.
module nibble_to_ascii
    import ascii_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/ascii_hex_sender.sv
// Sends a binary value as uppercase hex ASCII (optionally followed by CR LF)
// to a UART transmitter, one byte per frame, using a start/busy handshake.
module ascii_hex_sender
    import ascii_pkg::*;
#(
    parameter int NDIGITS   = 4,
    parameter int SEND_CRLF = 1
) (
    input  logic                   iClk,
    input  logic                   iReset_n,
    input  logic [4*NDIGITS-1:0]   ivValue,
    input  logic                   iSend,
    input  logic                   iTxBusy,
    output logic [7:0]             ovTxData,
    output logic                   oTxStart,
    output logic                   oBusy,
    output logic                   oDone
);

    localparam int VALUE_W = 4 * NDIGITS;
    localparam int NCHARS  = NDIGITS + 2 * SEND_CRLF;
    localparam int IDX_W   = $clog2(NCHARS + 1);

    state_t               state;
    state_t               state_next;
    logic [VALUE_W-1:0]   shift_reg;
    logic [VALUE_W-1:0]   shift_next;
    logic [IDX_W-1:0]     char_idx;
    logic [IDX_W-1:0]     idx_next;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 frame_done;
    logic                 last_char;
    logic                 advance;
    logic [3:0]           nib_sel;
    logic [7:0]           nib_ascii;
    logic [7:0]           char_next;

    // The done cycle is spent in IDLE, so a request there must still be refused.
    assign accept     = (state == ST_IDLE) && iSend && !done_q;
    assign frame_done = (state == ST_WAIT_DONE) && !iTxBusy;
    assign last_char  = (char_idx == IDX_W'(NCHARS - 1));
    assign advance    = frame_done && !last_char;
    assign shift_next = shift_reg << 4;

    // The character for the next ISSUE is prepared so ovTxData can be registered on entry.
    always_comb begin
        nib_sel  = shift_next[VALUE_W-1 -: 4];
        idx_next = char_idx + 1'b1;
        if (accept) begin
            nib_sel  = ivValue[VALUE_W-1 -: 4];
            idx_next = '0;
        end
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nib_sel),
        .ascii  (nib_ascii)
    );

    always_comb begin
        char_next = ASCII_LF;
        if (idx_next < IDX_W'(NDIGITS)) begin
            char_next = nib_ascii;
        end else if (idx_next == IDX_W'(NDIGITS)) begin
            char_next = ASCII_CR;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!iTxBusy) state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (iTxBusy) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!iTxBusy) state_next = last_char ? ST_IDLE : ST_ISSUE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            shift_reg <= '0;
            char_idx  <= '0;
            ovTxData  <= 8'h00;
        end else if (accept || advance) begin
            shift_reg <= accept ? ivValue : shift_next;
            char_idx  <= idx_next;
            ovTxData  <= char_next;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= frame_done && last_char;
            if (accept) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Start is gated by reset so an abort never launches a further frame.
    always_comb begin
        oTxStart = (state == ST_ISSUE) && !iTxBusy && iReset_n;
        oBusy    = busy_q;
        oDone    = done_q;
    end

endmodule

// File: tb/tb_ascii_hex_sender.sv
// Directed bench for ascii_hex_sender: default 4-digit CRLF instance plus a
// 2-digit no-CRLF instance, each driven by a simple UART busy model.
module tb_ascii_hex_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        send;
    logic        force_busy;
    logic        uart_busy = 1'b0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        done;

    logic [7:0]  value2;
    logic        send2;
    logic        uart_busy2 = 1'b0;
    logic [7:0]  tx_data2;
    logic        tx_start2;
    logic        busy2;
    logic        done2;

    int n_compared   = 0;
    int n_mismatched = 0;

    int          busy_cnt       = 0;
    int          start_cnt      = 0;
    int          done_cnt       = 0;
    int          illegal_starts = 0;
    logic [7:0]  rx_q[$];
    time         start_times[$];

    int          busy_cnt2  = 0;
    int          done2_cnt  = 0;
    logic [7:0]  rx2_q[$];

    always #5 clk = ~clk;

    assign tx_busy = uart_busy | force_busy;

    ascii_hex_sender u_dut (
        .iClk     (clk),
        .iReset_n (rst_n),
        .ivValue  (value),
        .iSend    (send),
        .iTxBusy  (tx_busy),
        .ovTxData (tx_data),
        .oTxStart (tx_start),
        .oBusy    (busy),
        .oDone    (done)
    );

    ascii_hex_sender #(.NDIGITS(2), .SEND_CRLF(0)) u_dut2 (
        .iClk     (clk),
        .iReset_n (rst_n),
        .ivValue  (value2),
        .iSend    (send2),
        .iTxBusy  (uart_busy2),
        .ovTxData (tx_data2),
        .oTxStart (tx_start2),
        .oBusy    (busy2),
        .oDone    (done2)
    );

    // UART model: a start launches a frame that keeps busy high for 10 cycles.
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (tx_start) begin
            if (tx_busy) illegal_starts++;
            rx_q.push_back(tx_data);
            start_times.push_back($time);
            start_cnt++;
            uart_busy <= 1'b1;
            busy_cnt  <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) uart_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (done2) done2_cnt++;
        if (tx_start2) begin
            rx2_q.push_back(tx_data2);
            uart_busy2 <= 1'b1;
            busy_cnt2  <= 3;
        end else if (busy_cnt2 > 0) begin
            busy_cnt2 <= busy_cnt2 - 1;
            if (busy_cnt2 == 1) uart_busy2 <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; send = 1'b0; value = '0; force_busy = 1'b0;
        send2 = 1'b0; value2 = '0;
        tick(3);
        n_compared++; if (tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_compared++; if (tx_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_compared++; if (tx_data2 !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tx_data2: got %h expected 00", tx_data2); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic_line();
        logic [7:0] exp[6] = '{8'h33, 8'h46, 8'h41, 8'h30, 8'h0D, 8'h0A};
        bit seen;
        int d0;
        logic [7:0] got;
        rx_q.delete(); start_times.delete(); d0 = done_cnt;
        value = 16'h3FA0; send = 1'b1;
        tick(1);
        send = 1'b0;
        n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL accept_busy: got %b expected 1", busy); end
        n_compared++; if (tx_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL accept_start: got %b expected 1", tx_start); end
        n_compared++; if (tx_data !== 8'h33) begin n_mismatched++; $display("[TB] FAIL accept_data: got %h expected 33", tx_data); end
        wait_done(500, seen);
        n_compared++; if (seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_done_timeout: got %b expected 1", seen); end
        n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL busy_in_done_cycle: got %b expected 1", busy); end
        tick(1);
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_after_done: got %b expected 0", busy); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
        n_compared++; if (done_cnt - d0 !== 1) begin n_mismatched++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        n_compared++; if (rx_q.size() !== 6) begin n_mismatched++; $display("[TB] FAIL basic_byte_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_compared++; if (got !== exp[i]) begin n_mismatched++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
        for (int i = 1; i < 6; i++) begin
            if (i < start_times.size()) begin
                n_compared++; if (start_times[i] - start_times[i-1] !== 120) begin n_mismatched++; $display("[TB] FAIL start_gap%0d: got %0t expected 120", i, start_times[i] - start_times[i-1]); end
            end
        end
    endtask

    task automatic test_all_digits();
        logic [15:0] vals[4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        logic [7:0]  exp[4][4] = '{'{8'h30, 8'h31, 8'h32, 8'h33},
                                   '{8'h34, 8'h35, 8'h36, 8'h37},
                                   '{8'h38, 8'h39, 8'h41, 8'h42},
                                   '{8'h43, 8'h44, 8'h45, 8'h46}};
        bit seen;
        logic [7:0] got;
        for (int v = 0; v < 4; v++) begin
            rx_q.delete();
            value = vals[v]; send = 1'b1;
            tick(1);
            send = 1'b0;
            wait_done(500, seen);
            tick(1);
            n_compared++; if (seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL digits%0d_timeout: got %b expected 1", v, seen); end
            n_compared++; if (rx_q.size() !== 6) begin n_mismatched++; $display("[TB] FAIL digits%0d_count: got %0d expected 6", v, rx_q.size()); end
            for (int i = 0; i < 4; i++) begin
                got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
                n_compared++; if (got !== exp[v][i]) begin n_mismatched++; $display("[TB] FAIL digits%0d_byte%0d: got %h expected %h", v, i, got, exp[v][i]); end
            end
        end
    endtask

    task automatic test_busy_at_start();
        logic [7:0] exp[6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        bit seen;
        int s0;
        logic [7:0] got;
        rx_q.delete(); s0 = start_cnt;
        force_busy = 1'b1;
        value = 16'h1234; send = 1'b1;
        tick(1);
        send = 1'b0; value = 16'hFFFF;
        n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL held_busy: got %b expected 1", busy); end
        n_compared++; if (tx_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL held_start_early: got %b expected 0", tx_start); end
        tick(4);
        n_compared++; if (start_cnt - s0 !== 0) begin n_mismatched++; $display("[TB] FAIL held_start_count: got %0d expected 0", start_cnt - s0); end
        force_busy = 1'b0;
        #1;
        n_compared++; if (tx_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL released_start: got %b expected 1", tx_start); end
        n_compared++; if (tx_data !== 8'h31) begin n_mismatched++; $display("[TB] FAIL released_data: got %h expected 31", tx_data); end
        wait_done(500, seen);
        tick(1);
        n_compared++; if (seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL held_timeout: got %b expected 1", seen); end
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_compared++; if (got !== exp[i]) begin n_mismatched++; $display("[TB] FAIL held_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_ignored_requests();
        logic [7:0] exp[6] = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        bit seen;
        int s0, d0;
        logic [7:0] got;
        rx_q.delete(); s0 = start_cnt; d0 = done_cnt;
        value = 16'hBEEF; send = 1'b1;
        tick(1);
        send = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick(3);
            value = 16'h1111 * k[15:0];
            send = 1'b1;
            tick(1);
            send = 1'b0;
        end
        wait_done(500, seen);
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(40);
        n_compared++; if (seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ignored_timeout: got %b expected 1", seen); end
        n_compared++; if (start_cnt - s0 !== 6) begin n_mismatched++; $display("[TB] FAIL ignored_start_count: got %0d expected 6", start_cnt - s0); end
        n_compared++; if (done_cnt - d0 !== 1) begin n_mismatched++; $display("[TB] FAIL ignored_done_count: got %0d expected 1", done_cnt - d0); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ignored_busy_after: got %b expected 0", busy); end
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_compared++; if (got !== exp[i]) begin n_mismatched++; $display("[TB] FAIL ignored_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int s0, d0;
        bit reached;
        s0 = start_cnt; d0 = done_cnt; reached = 1'b0;
        value = 16'hABCD; send = 1'b1;
        tick(1);
        send = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            tick(1);
            if (start_cnt - s0 >= 2) reached = 1'b1;
        end
        n_compared++; if (reached !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_progress: got %b expected 1", reached); end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(60);
        n_compared++; if (start_cnt - s0 !== 2) begin n_mismatched++; $display("[TB] FAIL midreset_starts: got %0d expected 2", start_cnt - s0); end
        n_compared++; if (done_cnt - d0 !== 0) begin n_mismatched++; $display("[TB] FAIL midreset_done: got %0d expected 0", done_cnt - d0); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        n_compared++; if (tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL midreset_data: got %h expected 00", tx_data); end
    endtask

    task automatic test_no_crlf();
        logic [7:0] exp[2] = '{8'h45, 8'h37};
        bit seen;
        int d0;
        logic [7:0] got;
        rx2_q.delete(); d0 = done2_cnt; seen = 1'b0;
        value2 = 8'hE7; send2 = 1'b1;
        tick(1);
        send2 = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(1);
            if (done2) seen = 1'b1;
        end
        tick(5);
        n_compared++; if (seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL nocrlf_timeout: got %b expected 1", seen); end
        n_compared++; if (rx2_q.size() !== 2) begin n_mismatched++; $display("[TB] FAIL nocrlf_count: got %0d expected 2", rx2_q.size()); end
        n_compared++; if (done2_cnt - d0 !== 1) begin n_mismatched++; $display("[TB] FAIL nocrlf_done_count: got %0d expected 1", done2_cnt - d0); end
        for (int i = 0; i < 2; i++) begin
            got = (i < rx2_q.size()) ? rx2_q[i] : 8'hxx;
            n_compared++; if (got !== exp[i]) begin n_mismatched++; $display("[TB] FAIL nocrlf_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_tx_protocol();
        n_compared++; if (illegal_starts !== 0) begin n_mismatched++; $display("[TB] FAIL start_while_busy: got %0d expected 0", illegal_starts); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_all_digits();
        test_busy_at_start();
        test_ignored_requests();
        test_mid_reset();
        test_no_crlf();
        test_tx_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
